// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory behind an RV32 load/store request port.
// Misaligned accesses either split across two word cycles or fault, depending on MISALIGN_EN.
module data_mem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int MISALIGN_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [2:0]  reqFunc3,
    input  logic [31:0] reqWdata,
    output logic        rspValid,
    output logic [31:0] rspData,
    output logic        rspFault
);

    localparam int WORDS = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} stateT;

    stateT              state;
    logic [31:0]        mem [WORDS];

    logic               latWrite;
    logic [ADDR_W-1:0]  latAddr;
    logic [2:0]         latFunc3;
    logic [31:0]        latWdata;
    logic [31:0]        loWord;

    logic               accept;
    logic [2:0]         reqSize;
    logic [32:0]        lastByte;
    logic               funcBad;
    logic               storeBad;
    logic               rangeBad;
    logic               misaligned;
    logic               reqFault;

    logic [1:0]         latOff;
    logic [3:0]         latSizeMask;
    logic [7:0]         latMask8;
    logic               latCross;
    logic [ADDR_W-3:0]  wordIdx;
    logic [ADDR_W-3:0]  nextWordIdx;
    logic [63:0]        wideWdata;

    assign accept = reqValid && reqReady;

    // Fault classification is done on the raw request so a faulting access never touches memory.
    always_comb begin
        reqSize    = 3'd1 << reqFunc3[1:0];
        lastByte   = {1'b0, reqAddr} + {30'b0, reqSize} - 33'd1;
        funcBad    = (reqFunc3 == 3'b011) || (reqFunc3 == 3'b110) || (reqFunc3 == 3'b111);
        storeBad   = reqWrite && reqFunc3[2];
        rangeBad   = (reqAddr[31:ADDR_W] != '0) || ((lastByte >> ADDR_W) != '0);
        misaligned = ((reqFunc3[1:0] == 2'b01) && reqAddr[0]) ||
                     ((reqFunc3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
        reqFault   = funcBad || storeBad || rangeBad || ((MISALIGN_EN == 0) && misaligned);
    end

    always_comb begin
        latOff = latAddr[1:0];
        case (latFunc3[1:0])
            2'b00:   latSizeMask = 4'b0001;
            2'b01:   latSizeMask = 4'b0011;
            default: latSizeMask = 4'b1111;
        endcase
        latMask8    = {4'b0000, latSizeMask} << latOff;
        latCross    = |latMask8[7:4];
        wordIdx     = latAddr[ADDR_W-1:2];
        nextWordIdx = wordIdx + {{(ADDR_W-3){1'b0}}, 1'b1};
        wideWdata   = {32'b0, latWdata} << {latOff, 3'b000};
    end

    function automatic logic [31:0] loadResult(input logic [63:0] window,
                                               input logic [1:0]  off,
                                               input logic [2:0]  func3);
        logic [31:0] s;
        s = 32'(window >> {off, 3'b000});
        case (func3)
            3'b000:  loadResult = {{24{s[7]}}, s[7:0]};
            3'b001:  loadResult = {{16{s[15]}}, s[15:0]};
            3'b100:  loadResult = {24'b0, s[7:0]};
            3'b101:  loadResult = {16'b0, s[15:0]};
            default: loadResult = s;
        endcase
    endfunction

    // Memory is deliberately not reset; an async reset forces IDLE so a pending ACC1 write is lost.
    always_ff @(posedge clk) begin
        if (state == ACC0 && latWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (latMask8[i]) mem[wordIdx][8*i +: 8] <= wideWdata[8*i +: 8];
            end
        end
        if (state == ACC1 && latWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (latMask8[4+i]) mem[nextWordIdx][8*i +: 8] <= wideWdata[32+8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            reqReady <= 1'b0;
            rspValid <= 1'b0;
            rspData  <= '0;
            rspFault <= 1'b0;
            latWrite <= 1'b0;
            latAddr  <= '0;
            latFunc3 <= '0;
            latWdata <= '0;
            loWord   <= '0;
        end else begin
            rspValid <= 1'b0;
            rspData  <= '0;
            rspFault <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        latWrite <= reqWrite;
                        latAddr  <= reqAddr[ADDR_W-1:0];
                        latFunc3 <= reqFunc3;
                        latWdata <= reqWdata;
                        if (reqFault) begin
                            state    <= RESP;
                            reqReady <= 1'b1;
                            rspValid <= 1'b1;
                            rspFault <= 1'b1;
                        end else begin
                            state    <= ACC0;
                            reqReady <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        reqReady <= 1'b1;
                    end
                end
                ACC0: begin
                    if (latCross) begin
                        state  <= ACC1;
                        loWord <= mem[wordIdx];
                    end else begin
                        state    <= RESP;
                        reqReady <= 1'b1;
                        rspValid <= 1'b1;
                        rspData  <= latWrite ? 32'h0 :
                                    loadResult({32'b0, mem[wordIdx]}, latOff, latFunc3);
                    end
                end
                ACC1: begin
                    state    <= RESP;
                    reqReady <= 1'b1;
                    rspValid <= 1'b1;
                    rspData  <= latWrite ? 32'h0 :
                                loadResult({mem[nextWordIdx], loWord}, latOff, latFunc3);
                end
                default: begin
                    state    <= IDLE;
                    reqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-level memory model plus a per-cycle response compare.
// A second instance with MISALIGN_EN=0 covers the alignment-fault behaviour.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid, reqReady, reqWrite, rspValid, rspFault;
    logic [31:0] reqAddr, reqWdata, rspData;
    logic [2:0]  reqFunc3;

    logic        m0Valid, m0Ready, m0Write, m0RspValid, m0RspFault;
    logic [31:0] m0Addr, m0Wdata, m0RspData;
    logic [2:0]  m0Func3;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_W(12), .MISALIGN_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqFunc3(reqFunc3), .reqWdata(reqWdata),
        .rspValid(rspValid), .rspData(rspData), .rspFault(rspFault)
    );

    data_mem_ctrl #(.ADDR_W(12), .MISALIGN_EN(0)) dutAligned (
        .clk(clk), .rst_n(rst_n),
        .reqValid(m0Valid), .reqReady(m0Ready), .reqWrite(m0Write),
        .reqAddr(m0Addr), .reqFunc3(m0Func3), .reqWdata(m0Wdata),
        .rspValid(m0RspValid), .rspData(m0RspData), .rspFault(m0RspFault)
    );

    typedef struct {
        int          cycle;
        logic [31:0] data;
        logic        fault;
    } expT;

    expT         expQ[$];
    logic [7:0]  modelMem [0:4095];
    int          checks = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          lastAccept = -100;
    int          lastBusyEnd = -100;
    int          lastRspCycle = -1;
    logic [31:0] lastRspData = '0;
    logic        lastRspFault = 1'b0;
    bit          readyCheckOn = 1'b0;
    bit          due;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h expected %h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    function automatic bit modelFault(input bit w, input logic [31:0] a, input logic [2:0] f, input bit misEn);
        int     size;
        longint last;
        if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b1;
        if (w && (f == 3'b100 || f == 3'b101)) return 1'b1;
        size = 1 << f[1:0];
        last = longint'({32'b0, a}) + size - 1;
        if (last > 4095) return 1'b1;
        if (!misEn && (int'(a[1:0]) % size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] f);
        int          size;
        logic [31:0] v;
        size = 1 << f[1:0];
        v = '0;
        for (int k = 0; k < size; k++) v[8*k +: 8] = modelMem[int'(a) + k];
        if (f == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
        if (f == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic modelStore(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int size;
        size = 1 << f[1:0];
        for (int k = 0; k < size; k++) modelMem[int'(a) + k] = d[8*k +: 8];
    endtask

    // Called at a negedge; holds the request until accepted, then records what the model expects.
    task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        int          waited;
        bit          flt;
        int          size;
        int          lat;
        logic [31:0] ld;
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqFunc3 = f;
        reqWdata = d;
        waited   = 0;
        while (reqReady !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout: actual reqReady=%b required 1 within 20 cycles", reqReady);
            reqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lastAccept = cycleCount;
        flt  = modelFault(w, a, f, 1'b1);
        size = 1 << f[1:0];
        lat  = flt ? 1 : ((int'(a[1:0]) + size > 4) ? 3 : 2);
        ld   = (flt || w) ? 32'h0 : modelLoad(a, f);
        expQ.push_back('{lastAccept + lat - 1, ld, flt});
        lastBusyEnd = lastAccept + lat - 2;
        if (!flt && w) modelStore(a, f, d);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic waitIdle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkLast(input string name, input logic [31:0] expData, input logic expFault, input int expLat);
        waitIdle(3);
        checkOutput({name, " data"}, lastRspData, expData);
        checkOutput({name, " fault"}, {31'b0, lastRspFault}, {31'b0, expFault});
        checkOutput({name, " latency"}, lastRspCycle - lastAccept + 1, expLat);
    endtask

    // Per-cycle compare of the main instance against the model's expectation queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            checkOutput("resetRspValid", {31'b0, rspValid}, 32'h0);
            checkOutput("resetRspData", rspData, 32'h0);
            checkOutput("resetRspFault", {31'b0, rspFault}, 32'h0);
        end else begin
            due = (expQ.size() > 0) && (expQ[0].cycle == cycleCount);
            checkOutput("rspValid", {31'b0, rspValid}, {31'b0, due});
            if (rspValid) begin
                lastRspCycle = cycleCount;
                lastRspData  = rspData;
                lastRspFault = rspFault;
            end
            if (due) begin
                checkOutput("rspData", rspData, expQ[0].data);
                checkOutput("rspFault", {31'b0, rspFault}, {31'b0, expQ[0].fault});
                void'(expQ.pop_front());
            end else if (expQ.size() > 0 && expQ[0].cycle < cycleCount) begin
                void'(expQ.pop_front());
            end
            if (readyCheckOn)
                checkOutput("reqReady", {31'b0, reqReady},
                            {31'b0, !(cycleCount >= lastAccept && cycleCount <= lastBusyEnd)});
        end
    end

    logic [31:0] m0AddrTab  [4] = '{32'h22, 32'h20, 32'h21, 32'h23};
    logic [2:0]  m0FuncTab  [4] = '{3'b010, 3'b010, 3'b001, 3'b000};
    logic        m0FaultTab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int          m0LatTab   [4] = '{1, 2, 1, 2};

    initial begin
        int          prevAccept;
        int          gotLat;
        logic        gotFault;
        logic [31:0] gotData;
        logic [31:0] d;
        int          w;

        reqValid = 0; reqWrite = 0; reqAddr = 0; reqFunc3 = 0; reqWdata = 0;
        m0Valid = 0; m0Write = 0; m0Addr = 0; m0Func3 = 0; m0Wdata = 0;
        for (int i = 0; i < 4096; i++) modelMem[i] = 8'h00;

        waitIdle(3);
        checkOutput("alignedResetValid", {31'b0, m0RspValid}, 32'h0);
        rst_n = 1'b1;
        waitIdle(1);
        checkOutput("readyAfterReset", {31'b0, reqReady}, 32'h1);
        readyCheckOn = 1'b1;

        // Known contents for the low 64 bytes: byte b holds b ^ 0x5A.
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(4*i + k) ^ 8'h5A;
            applyStimulus(1'b1, 32'(4*i), 3'b010, d);
        end

        applyStimulus(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h10, 3'b010, 32'h0);
        checkLast("LW 0x10", 32'hDEAD_BEEF, 1'b0, 2);
        applyStimulus(1'b0, 32'h13, 3'b100, 32'h0);
        checkLast("LBU 0x13", 32'h0000_00DE, 1'b0, 2);
        applyStimulus(1'b0, 32'h10, 3'b000, 32'h0);
        checkLast("LB 0x10", 32'hFFFF_FFEF, 1'b0, 2);

        applyStimulus(1'b1, 32'h20, 3'b010, 32'h1122_3344);
        applyStimulus(1'b1, 32'h24, 3'b010, 32'h5566_7788);
        applyStimulus(1'b0, 32'h22, 3'b010, 32'h0);
        checkLast("LW 0x22", 32'h7788_1122, 1'b0, 3);

        applyStimulus(1'b1, 32'h23, 3'b001, 32'h0000_ABCD);
        applyStimulus(1'b0, 32'h23, 3'b101, 32'h0);
        checkLast("LHU 0x23", 32'h0000_ABCD, 1'b0, 3);
        applyStimulus(1'b0, 32'h23, 3'b001, 32'h0);
        checkLast("LH 0x23", 32'hFFFF_ABCD, 1'b0, 3);
        applyStimulus(1'b0, 32'h22, 3'b100, 32'h0);
        checkLast("LBU 0x22", 32'h0000_0022, 1'b0, 2);
        applyStimulus(1'b0, 32'h25, 3'b100, 32'h0);
        checkLast("LBU 0x25", 32'h0000_0077, 1'b0, 2);
        applyStimulus(1'b0, 32'h21, 3'b001, 32'h0);
        checkLast("LH 0x21", 32'h0000_2233, 1'b0, 2);

        applyStimulus(1'b0, 32'h1000, 3'b010, 32'h0);
        checkLast("LW 0x1000", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'hFFE, 3'b010, 32'h0);
        checkLast("LW 0xFFE", 32'h0, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 3'b011, 32'h0);
        checkLast("funct3 011", 32'h0, 1'b1, 1);
        applyStimulus(1'b1, 32'h4, 3'b100, 32'hFF);
        applyStimulus(1'b0, 32'h8000_0010, 3'b000, 32'h0);
        applyStimulus(1'b1, 32'hFFC, 3'b010, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'hFFC, 3'b010, 32'h0);
        checkLast("LW 0xFFC", 32'hCAFE_F00D, 1'b0, 2);
        applyStimulus(1'b0, 32'hFFF, 3'b000, 32'h0);
        checkLast("LB 0xFFF", 32'hFFFF_FFCA, 1'b0, 2);

        // Back-to-back alternating SW/LW with reqValid held high, ending on a fault from RESP.
        applyStimulus(1'b1, 32'h0, 3'b010, 32'h100);
        for (int i = 1; i < 6; i++) begin
            prevAccept = lastAccept;
            if (i == 5) applyStimulus(1'b0, 32'h1000, 3'b010, 32'h0);
            else        applyStimulus(i[0] ? 1'b0 : 1'b1, 32'h0, 3'b010, 32'(32'h100 + i));
            checkOutput("b2bSpacing", 32'(lastAccept - prevAccept), 32'd2);
        end
        waitIdle(3);

        // Crossing store interrupted by reset in its ACC1 cycle.
        readyCheckOn = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h2E; reqFunc3 = 3'b010; reqWdata = 32'h0102_0304;
        @(posedge clk);
        #1;
        modelMem[32'h2E] = 8'h04;
        modelMem[32'h2F] = 8'h03;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        waitIdle(2);
        rst_n = 1'b1;
        lastAccept  = -100;
        lastBusyEnd = -100;
        waitIdle(3);
        readyCheckOn = 1'b1;
        applyStimulus(1'b0, 32'h2E, 3'b101, 32'h0);
        checkLast("LHU 0x2E", 32'h0000_0304, 1'b0, 2);
        applyStimulus(1'b0, 32'h30, 3'b101, 32'h0);
        checkLast("LHU 0x30", 32'h0000_6B6A, 1'b0, 2);

        // Alignment-fault instance: literal expectations only.
        for (int t = 0; t < 4; t++) begin
            m0Valid = 1'b1; m0Write = 1'b0; m0Addr = m0AddrTab[t]; m0Func3 = m0FuncTab[t];
            @(posedge clk);
            gotLat = 0; gotFault = 1'b0; gotData = '0;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                m0Valid = 1'b0;
                if (m0RspValid && gotLat == 0) begin
                    gotLat = k; gotFault = m0RspFault; gotData = m0RspData;
                end
            end
            checkOutput("alignedLatency", 32'(gotLat), 32'(m0LatTab[t]));
            checkOutput("alignedFault", {31'b0, gotFault}, {31'b0, m0FaultTab[t]});
            if (m0FaultTab[t]) checkOutput("alignedFaultData", gotData, 32'h0);
        end

        w = 0;
        while (expQ.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: actual %0d responses outstanding required 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
